// File: rtl/bnn_pkg.sv
// Shared definitions for binary convolution layers: window geometry,
// match width and the XNOR-popcount / threshold helpers.
package bnn_pkg;

  localparam int WIN_TAPS = 9;
  localparam int MATCH_W  = 4;

  typedef struct packed {
    logic valid;
    logic last;
  } win_flags_t;

  function automatic logic [MATCH_W-1:0] popcount9(input logic [WIN_TAPS-1:0] bits);
    logic [MATCH_W-1:0] cnt;
    cnt = 4'd0;
    for (int k = 0; k < WIN_TAPS; k++) begin
      cnt = cnt + {3'd0, bits[k]};
    end
    return cnt;
  endfunction

  function automatic logic thresh_pass(input logic [MATCH_W-1:0] match,
                                       input logic [MATCH_W-1:0] thresh);
    return (match >= thresh);
  endfunction

endpackage

// File: rtl/bin_conv3x3_layer_if.sv
// Pixel-in / channel-bits-out stream bundle of the binary 3x3 conv layer.
interface bin_conv3x3_layer_if #(parameter int CH_OUT = 8);
  logic              pixel_in;
  logic              valid_in;
  logic              sof_in;
  logic [CH_OUT-1:0] conv_out;
  logic              valid_out;
  logic              last_out;

  modport master (output pixel_in, valid_in, sof_in,
                  input  conv_out, valid_out, last_out);
  modport slave  (input  pixel_in, valid_in, sof_in,
                  output conv_out, valid_out, last_out);
endinterface

// File: rtl/bin_line_window.sv
// Raster position tracking, two line buffers and the 3x3 sliding window.
// The window includes the pixel being accepted, so it is combinational.
module bin_line_window
  import bnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pixel,
  input  logic                valid,
  input  logic                sof,
  output logic [WIN_TAPS-1:0] window,
  output win_flags_t          flags
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  // last stride-aligned position: (pos-2) must be even
  localparam int LAST_ROW = ((STRIDE == 2) && (((IMG_H - 3) % 2) == 1)) ? IMG_H - 2 : IMG_H - 1;
  localparam int LAST_COL = ((STRIDE == 2) && (((IMG_W - 3) % 2) == 1)) ? IMG_W - 2 : IMG_W - 1;

  if ((STRIDE != 1) && (STRIDE != 2)) begin : g_bad_stride
    $error("bin_line_window: STRIDE must be 1 or 2");
  end

  logic [COL_W-1:0] col_r, pos_col_s, next_col_s;
  logic [ROW_W-1:0] row_r, pos_row_s, next_row_s;
  logic [IMG_W-1:0] lb_near_r, lb_far_r;
  logic [2:0]       col_a_r, col_b_r, col_new_s;
  logic             aligned_s;

  // Position of the current pixel and the position that follows it
  always_comb begin
    pos_col_s  = col_r;
    pos_row_s  = row_r;
    next_col_s = col_r;
    next_row_s = row_r;
    if (sof) begin
      pos_col_s = '0;
      pos_row_s = '0;
    end else begin
      pos_col_s = col_r;
      pos_row_s = row_r;
    end
    if (pos_col_s == COL_W'(IMG_W - 1)) begin
      next_col_s = '0;
      if (pos_row_s == ROW_W'(IMG_H - 1)) begin
        next_row_s = '0;
      end else begin
        next_row_s = pos_row_s + ROW_W'(1);
      end
    end else begin
      next_col_s = pos_col_s + COL_W'(1);
      next_row_s = pos_row_s;
    end
  end

  // Window assembly and valid/last flags for the current pixel
  always_comb begin
    col_new_s = {pixel, lb_near_r[pos_col_s], lb_far_r[pos_col_s]};
    for (int i = 0; i < 3; i++) begin
      window[3*i]     = col_a_r[i];
      window[3*i + 1] = col_b_r[i];
      window[3*i + 2] = col_new_s[i];
    end
    aligned_s = (STRIDE == 2) ? (~pos_row_s[0] & ~pos_col_s[0]) : 1'b1;
    flags     = '0;
    if (valid && (pos_row_s >= ROW_W'(2)) && (pos_col_s >= COL_W'(2)) && aligned_s) begin
      flags.valid = 1'b1;
      flags.last  = (pos_row_s == ROW_W'(LAST_ROW)) && (pos_col_s == COL_W'(LAST_COL));
    end else begin
      flags = '0;
    end
  end

  // Counters, line buffers and window columns advance on accepted pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r     <= '0;
      row_r     <= '0;
      lb_near_r <= '0;
      lb_far_r  <= '0;
      col_a_r   <= 3'd0;
      col_b_r   <= 3'd0;
    end else if (valid) begin
      col_r                <= next_col_s;
      row_r                <= next_row_s;
      lb_far_r[pos_col_s]  <= lb_near_r[pos_col_s];
      lb_near_r[pos_col_s] <= pixel;
      col_a_r              <= col_b_r;
      col_b_r              <= col_new_s;
    end
  end

endmodule

// File: rtl/bin_conv3x3_layer.sv
// Binary 3x3 convolution layer: per-channel XNOR-popcount of the sliding
// window against fixed weights, thresholded to one registered bit each.
module bin_conv3x3_layer
  import bnn_pkg::*;
#(
  parameter int                     IMG_W   = 28,
  parameter int                     IMG_H   = 28,
  parameter int                     CH_OUT  = 8,
  parameter int                     STRIDE  = 1,
  parameter logic [CH_OUT*9-1:0]    WEIGHTS = '1,
  parameter logic [CH_OUT*4-1:0]    THRESH  = {CH_OUT{4'd9}}
) (
  input  logic               clk,
  input  logic               rst_n,
  bin_conv3x3_layer_if.slave bus
);

  logic [WIN_TAPS-1:0] window_s;
  win_flags_t          flags_s;
  logic [CH_OUT-1:0]   conv_s;
  logic [CH_OUT-1:0]   conv_r;
  logic                valid_r;
  logic                last_r;

  bin_line_window #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .STRIDE (STRIDE)
  ) u_window (
    .clk    (clk),
    .rst_n  (rst_n),
    .pixel  (bus.pixel_in),
    .valid  (bus.valid_in),
    .sof    (bus.sof_in),
    .window (window_s),
    .flags  (flags_s)
  );

  for (genvar c = 0; c < CH_OUT; c++) begin : g_ch
    logic [MATCH_W-1:0] match_s;
    assign match_s   = popcount9(~(window_s ^ WEIGHTS[c*WIN_TAPS +: WIN_TAPS]));
    assign conv_s[c] = thresh_pass(match_s, THRESH[c*MATCH_W +: MATCH_W]);
  end

  // Output registers; channel bits hold between windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      valid_r <= flags_s.valid;
      last_r  <= flags_s.last;
      if (flags_s.valid) begin
        conv_r <= conv_s;
      end
    end
  end

  assign bus.conv_out  = conv_r;
  assign bus.valid_out = valid_r;
  assign bus.last_out  = last_r;

endmodule

// File: tb/tb_bin_conv3x3_layer.sv
// Bench for bin_conv3x3_layer: a default 8-channel stride-1 layer and a
// 3-channel stride-2 layer share one pixel stream and an image-array model.
module tb_bin_conv3x3_layer;

  localparam int W = 28;
  localparam int H = 28;
  localparam logic [71:0] WA = {72{1'b1}};
  localparam logic [31:0] TA = {8{4'd9}};
  localparam logic [26:0] WB = {9'h1A5, 9'h0F3, 9'h155};
  localparam logic [11:0] TB = {4'd0, 4'd5, 4'd9};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix = 1'b0, vin = 1'b0, sof = 1'b0;

  bin_conv3x3_layer_if #(.CH_OUT(8)) ifa ();
  bin_conv3x3_layer_if #(.CH_OUT(3)) ifb ();

  assign ifa.pixel_in = pix;
  assign ifa.valid_in = vin;
  assign ifa.sof_in   = sof;
  assign ifb.pixel_in = pix;
  assign ifb.valid_in = vin;
  assign ifb.sof_in   = sof;

  bin_conv3x3_layer #(.IMG_W(W), .IMG_H(H), .CH_OUT(8), .STRIDE(1),
                      .WEIGHTS(WA), .THRESH(TA))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  bin_conv3x3_layer #(.IMG_W(W), .IMG_H(H), .CH_OUT(3), .STRIDE(2),
                      .WEIGHTS(WB), .THRESH(TB))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state: image of the current frame and the frame position
  bit img [H][W];
  int m_row = 0, m_col = 0;
  logic exp_va = 1'b0, exp_la = 1'b0, exp_vb = 1'b0, exp_lb = 1'b0;
  logic [7:0] exp_ca = 8'd0, exp_cb = 8'd0;

  int cnt_a, cnt_b, lst_a, lst_b, b0_ones, accepted, first_idx;

  typedef struct {
    int pat;     // 0 ones, 1 checker, 2 inverted checker, 3 random
    int gap;     // idle percentage
    int pre;     // pixels of an aborted frame before the measured one
    bit use_sof;
    int exp_a;
    int exp_b;
    int exp_b0;  // -1: not checked
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_conv(int r, int c, int nch,
                                            logic [71:0] w, logic [31:0] t);
    logic [7:0] res;
    res = 8'd0;
    for (int ch = 0; ch < nch; ch++) begin
      int m;
      m = 0;
      for (int k = 0; k < 9; k++) begin
        if (img[r-2+k/3][c-2+k%3] == w[ch*9+k]) m++;
      end
      res[ch] = (m >= int'(t[ch*4 +: 4]));
    end
    return res;
  endfunction

  task automatic model_accept(input logic p, input logic s);
    if (s) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = p;
    exp_va = (m_row >= 2) && (m_col >= 2);
    exp_la = exp_va && (m_row == H-1) && (m_col == W-1);
    exp_vb = exp_va && ((m_row - 2) % 2 == 0) && ((m_col - 2) % 2 == 0);
    exp_lb = exp_vb && (m_row == 26) && (m_col == 26);
    if (exp_va) exp_ca = model_conv(m_row, m_col, 8, WA, TA);
    if (exp_vb) exp_cb = model_conv(m_row, m_col, 3, 72'(WB), 32'(TB));
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_row = 0;
    end
  endtask

  task automatic check_outputs();
    chk("valid_a", 32'(ifa.valid_out), 32'(exp_va));
    chk("last_a",  32'(ifa.last_out),  32'(exp_la));
    chk("conv_a",  32'(ifa.conv_out),  32'(exp_ca));
    chk("valid_b", 32'(ifb.valid_out), 32'(exp_vb));
    chk("last_b",  32'(ifb.last_out),  32'(exp_lb));
    chk("conv_b",  32'(ifb.conv_out),  32'(exp_cb));
    if (ifa.valid_out) cnt_a++;
    if (ifb.valid_out) cnt_b++;
    if (ifa.last_out) lst_a++;
    if (ifb.last_out) lst_b++;
    if (ifb.valid_out && ifb.conv_out[0]) b0_ones++;
    if (ifa.valid_out && first_idx < 0) first_idx = accepted - 1;
  endtask

  task automatic step(input logic p, input logic v, input logic s);
    @(negedge clk);
    check_outputs();
    pix = p;
    vin = v;
    sof = s;
    if (v) begin
      accepted++;
      model_accept(p, s);
    end else begin
      exp_va = 1'b0; exp_la = 1'b0; exp_vb = 1'b0; exp_lb = 1'b0;
    end
  endtask

  task automatic send(input logic p, input logic s, input int gap);
    while ($urandom_range(99) < gap) step(1'($urandom), 1'b0, 1'($urandom));
    step(p, 1'b1, s);
  endtask

  function automatic logic pattern_px(int pat, int r, int c);
    case (pat)
      0: return 1'b1;
      1: return 1'((r + c) % 2);
      2: return 1'((r + c + 1) % 2);
      default: return 1'($urandom);
    endcase
  endfunction

  task automatic clear_counts();
    cnt_a = 0; cnt_b = 0; lst_a = 0; lst_b = 0; b0_ones = 0;
    accepted = 0; first_idx = -1;
  endtask

  task automatic run_frame(input int pat, input int gap, input bit use_sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(pattern_px(pat, r, c), use_sof && (r == 0) && (c == 0), gap);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{0, 0,  0,   1'b0, 676, 169, 0};
    vecs[1] = '{0, 30, 0,   1'b0, 676, 169, 0};
    vecs[2] = '{1, 0,  0,   1'b1, 676, 169, 0};
    vecs[3] = '{2, 20, 0,   1'b0, 676, 169, 169};
    vecs[4] = '{3, 30, 0,   1'b0, 676, 169, -1};
    vecs[5] = '{0, 0,  300, 1'b0, 902, 230, 0};

    clear_counts();
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid_a", 32'(ifa.valid_out), 32'd0);
    chk("reset_conv_a",  32'(ifa.conv_out),  32'd0);
    chk("reset_last_b",  32'(ifb.last_out),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      clear_counts();
      for (int p = 0; p < vecs[i].pre; p++)
        send(pattern_px(vecs[i].pat, p / W, p % W), 1'b0, vecs[i].gap);
      run_frame(vecs[i].pat, vecs[i].gap, vecs[i].use_sof || (vecs[i].pre > 0));
      chk($sformatf("pulses_a[%0d]", i), 32'(cnt_a), 32'(vecs[i].exp_a));
      chk($sformatf("pulses_b[%0d]", i), 32'(cnt_b), 32'(vecs[i].exp_b));
      chk($sformatf("lasts_a[%0d]", i),  32'(lst_a), 32'd1);
      chk($sformatf("lasts_b[%0d]", i),  32'(lst_b), 32'd1);
      if (vecs[i].exp_b0 >= 0)
        chk($sformatf("ch0_ones_b[%0d]", i), 32'(b0_ones), 32'(vecs[i].exp_b0));
      if (i == 0)
        chk("first_valid_pixel", 32'(first_idx), 32'd58);
    end

    // asynchronous reset in the middle of an all-ones frame
    clear_counts();
    for (int p = 0; p < 200; p++) send(1'b1, 1'b0, 0);
    @(negedge clk);
    check_outputs();
    chk("pre_reset_valid_a", 32'(ifa.valid_out), 32'd1);
    #2 rst_n = 1'b0;
    vin = 1'b0;
    #1;
    chk("midreset_valid_a", 32'(ifa.valid_out), 32'd0);
    chk("midreset_conv_a",  32'(ifa.conv_out),  32'd0);
    chk("midreset_valid_b", 32'(ifb.valid_out), 32'd0);
    chk("midreset_conv_b",  32'(ifb.conv_out),  32'd0);
    m_row = 0; m_col = 0;
    exp_va = 1'b0; exp_la = 1'b0; exp_vb = 1'b0; exp_lb = 1'b0;
    exp_ca = 8'd0; exp_cb = 8'd0;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    clear_counts();
    run_frame(3, 10, 1'b0);
    chk("post_reset_pulses_a", 32'(cnt_a), 32'd676);
    chk("post_reset_pulses_b", 32'(cnt_b), 32'd169);
    chk("post_reset_lasts_a",  32'(lst_a), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
